// File: rtl/fifo36_byte_unpacker.sv
// rtl/fifo36_byte_unpacker.sv - drains FWFT 36-bit words into a valid/ready byte stream, LSB first.
// Optional BYTE_COUNTER_EN adds accepted-byte and dropped-word counters.
module fifo36_byte_unpacker (
  input  logic        clk,
  input  logic        reset,
  input  logic [35:0] fifoData,
  input  logic        fifoEmpty,
  output logic        fifoReadEnable,
  output logic [7:0]  byteOut,
  output logic        byteValid,
  input  logic        byteReady,
  output logic [31:0] byteCount,
  output logic [15:0] dropCount
);

  typedef enum logic {IDLE, EMIT} state_t;

  state_t      state_q, state_d;
  logic [31:0] word_q, word_d;
  logic [3:0]  mask_q, mask_d;
  logic [3:0]  mask_rest;
  logic        xfer;

  always_comb begin
    state_d   = state_q;
    word_d    = word_q;
    mask_d    = mask_q;
    // Clearing the lowest set bit gives the mask left after this byte goes.
    mask_rest = mask_q & (mask_q - 4'd1);
    byteValid = (state_q == EMIT) && !reset;
    xfer      = byteValid && byteReady;

    byteOut = 8'h00;
    if (byteValid) begin
      if (mask_q[0])      byteOut = word_q[7:0];
      else if (mask_q[1]) byteOut = word_q[15:8];
      else if (mask_q[2]) byteOut = word_q[23:16];
      else                byteOut = word_q[31:24];
    end

    fifoReadEnable = !reset && !fifoEmpty &&
                     ((state_q == IDLE) || (xfer && (mask_rest == 4'd0)));

    if (xfer) begin
      mask_d = mask_rest;
      if (mask_rest == 4'd0) state_d = IDLE;
    end
    if (fifoReadEnable) begin
      word_d  = fifoData[31:0];
      mask_d  = fifoData[35:32];
      state_d = (fifoData[35:32] != 4'd0) ? EMIT : IDLE;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      word_q  <= 32'd0;
      mask_q  <= 4'd0;
    end else begin
      state_q <= state_d;
      word_q  <= word_d;
      mask_q  <= mask_d;
    end
  end

`ifdef BYTE_COUNTER_EN
  logic [31:0] byte_count_q, byte_count_d;
  logic [15:0] drop_count_q, drop_count_d;

  always_comb begin
    byte_count_d = byte_count_q;
    drop_count_d = drop_count_q;
    if (xfer) byte_count_d = byte_count_q + 32'd1;
    if (fifoReadEnable && (fifoData[35:32] == 4'd0)) drop_count_d = drop_count_q + 16'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      byte_count_q <= 32'd0;
      drop_count_q <= 16'd0;
    end else begin
      byte_count_q <= byte_count_d;
      drop_count_q <= drop_count_d;
    end
  end

  assign byteCount = byte_count_q;
  assign dropCount = drop_count_q;
`else
  assign byteCount = 32'd0;
  assign dropCount = 16'd0;
`endif

endmodule
